// File: rtl/button_pulser.sv
// Push-button conditioner: synchronizes a raw button, debounces press and release,
// and emits one enable pulse per accepted press plus optional auto-repeat pulses.
//
// state        | meaning
// IDLE         | released, waiting for a pressed sample
// PRESS_WAIT   | counting stable pressed samples before accepting the press
// HELD         | press accepted, waiting out the repeat delay
// REPEAT       | auto-repeating every REPEAT_PERIOD cycles
// RELEASE_WAIT | counting stable released samples; level still high
module button_pulser #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 10,
   parameter int unsigned REPEAT_PERIOD   = 3,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   input  logic repeat_en,
   output logic pulse,
   output logic level,
   output logic release_pulse
);

   localparam int unsigned MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int unsigned CNT_MAX = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      REPEAT       = 3'd3,
      RELEASE_WAIT = 3'd4
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic          s1_q;
   logic          s2_q;
   logic          pulse_q;
   logic          level_q;
   logic          release_q;
   logic          s;

   // Polarity-normalized synchronized button: 1 means pressed.
   assign s = s2_q ^ ACTIVE_LOW;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         s1_q      <= ACTIVE_LOW;
         s2_q      <= ACTIVE_LOW;
         pulse_q   <= 1'b0;
         level_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         s1_q      <= btn_in;
         s2_q      <= s1_q;
         pulse_q   <= 1'b0;
         release_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               level_q <= 1'b0;
               if (s) begin
                  state_q <= PRESS_WAIT;
                  cnt_q   <= CNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == DB_LAST) begin
                  state_q <= HELD;
                  pulse_q <= 1'b1;
                  level_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HELD: begin
               if (!s) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= CNT_ONE;
               end else if (repeat_en && (cnt_q >= RD_LAST)) begin
                  state_q <= REPEAT;
                  pulse_q <= 1'b1;
                  cnt_q   <= '0;
               end else if (cnt_q < RD_LAST) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            REPEAT: begin
               // A release outranks a repeat pulse due in the same cycle.
               if (!s) begin
                  state_q <= RELEASE_WAIT;
                  cnt_q   <= CNT_ONE;
               end else if (!repeat_en) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
               end else if (cnt_q == RP_LAST) begin
                  pulse_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state_q <= HELD;
                  cnt_q   <= '0;
               end else if (cnt_q == DB_LAST) begin
                  state_q   <= IDLE;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

   assign pulse         = pulse_q;
   assign level         = level_q;
   assign release_pulse = release_q;

endmodule
